// File: rtl/wake_table_pkg.sv
// rtl/wake_table_pkg.sv - shared types, sizes and popcount for the wake scoreboard
package wake_table_pkg;

    localparam int PHY_REGS = 64;
    localparam int IDX_W    = 6;

    typedef logic [IDX_W-1:0]    phy_idx;
    typedef logic [0:PHY_REGS-1] wake_vec;

    // Register 0 is permanently ready, so it never counts as busy.
    function automatic logic [6:0] busy_popcount(input wake_vec v);
        logic [6:0] cnt;
        cnt = '0;
        for (int i = 1; i < PHY_REGS; i++) begin
            cnt = cnt + {6'd0, ~v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/wake_table_delay_line.sv
// rtl/wake_table_delay_line.sv - per-port {valid, index} shift register delaying write-port wakes
module wake_delay_line
    import wake_table_pkg::*;
#(
    parameter int WAKE_LAT = 1,
    parameter int NUM_WB   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [NUM_WB-1:0]       wb_we,
    input  logic [NUM_WB*IDX_W-1:0] wb_dst,
    input  logic [0:PHY_REGS-1]     kill,
    output logic [NUM_WB-1:0]       mat_valid,
    output logic [NUM_WB*IDX_W-1:0] mat_dst
);

    if (WAKE_LAT == 0) begin : g_wire
        logic unused_inputs;
        assign unused_inputs = ^{clk, rst, flush, kill};
        assign mat_valid     = wb_we;
        assign mat_dst       = wb_dst;
    end else begin : g_pipe
        logic [NUM_WB-1:0]       v_q [WAKE_LAT];
        logic [NUM_WB*IDX_W-1:0] d_q [WAKE_LAT];

        // Entries whose index is being reallocated drop out as they shift,
        // so a stale wake can never raise a freshly allocated register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int s = 0; s < WAKE_LAT; s++) begin
                    v_q[s] <= '0;
                    d_q[s] <= '0;
                end
            end else if (flush) begin
                for (int s = 0; s < WAKE_LAT; s++) begin
                    v_q[s] <= '0;
                    d_q[s] <= '0;
                end
            end else begin
                for (int j = 0; j < NUM_WB; j++) begin
                    v_q[0][j] <= wb_we[j] && !kill[wb_dst[j*IDX_W +: IDX_W]];
                end
                d_q[0] <= wb_dst;
                for (int s = 1; s < WAKE_LAT; s++) begin
                    for (int j = 0; j < NUM_WB; j++) begin
                        v_q[s][j] <= v_q[s-1][j] && !kill[d_q[s-1][j*IDX_W +: IDX_W]];
                    end
                    d_q[s] <= d_q[s-1];
                end
            end
        end

        assign mat_valid = v_q[WAKE_LAT-1];
        assign mat_dst   = d_q[WAKE_LAT-1];
    end

endmodule

// File: rtl/wake_table.sv
// rtl/wake_table.sv - physical-register readiness scoreboard driving the EX-slot wake list
module wake_table
    import wake_table_pkg::*;
#(
    parameter int NUM_ALLOC = 2,
    parameter int NUM_WB    = 4,
    parameter int WAKE_LAT  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic                       flush,
    input  logic [NUM_ALLOC-1:0]       alloc_en,
    input  logic [NUM_ALLOC*IDX_W-1:0] alloc_dst,
    input  logic [NUM_WB-1:0]          wb_we,
    input  logic [NUM_WB*IDX_W-1:0]    wb_dst,
    output logic [0:63]                wake_list,
    output logic [6:0]                 busy_count,
    output logic                       err
);

    logic [NUM_ALLOC-1:0]    alloc_eff;
    wake_vec                 kill;
    wake_vec                 nxt;
    logic                    err_hit;
    logic [NUM_WB-1:0]       mat_valid;
    logic [NUM_WB*IDX_W-1:0] mat_dst;

    wake_delay_line #(
        .WAKE_LAT (WAKE_LAT),
        .NUM_WB   (NUM_WB)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .wb_we     (wb_we),
        .wb_dst    (wb_dst),
        .kill      (kill),
        .mat_valid (mat_valid),
        .mat_dst   (mat_dst)
    );

    always_comb begin
        alloc_eff = '0;
        kill      = '0;
        err_hit   = 1'b0;
        nxt       = wake_list;

        for (int k = 0; k < NUM_ALLOC; k++) begin
            alloc_eff[k] = alloc_en[k] && !stall && !flush &&
                           (alloc_dst[k*IDX_W +: IDX_W] != '0);
            if (alloc_eff[k]) begin
                kill[alloc_dst[k*IDX_W +: IDX_W]] = 1'b1;
            end
        end

        // Writes below allocs below flush gives flush > alloc > wake per bit.
        for (int j = 0; j < NUM_WB; j++) begin
            if (mat_valid[j]) begin
                nxt[mat_dst[j*IDX_W +: IDX_W]] = 1'b1;
            end
        end
        for (int k = 0; k < NUM_ALLOC; k++) begin
            if (alloc_eff[k]) begin
                nxt[alloc_dst[k*IDX_W +: IDX_W]] = 1'b0;
            end
        end
        if (flush) begin
            nxt = '1;
        end
        nxt[0] = 1'b1;

        for (int k = 0; k < NUM_ALLOC; k++) begin
            if (alloc_eff[k] && !wake_list[alloc_dst[k*IDX_W +: IDX_W]]) begin
                err_hit = 1'b1;
            end
            for (int l = k + 1; l < NUM_ALLOC; l++) begin
                if (alloc_eff[k] && alloc_eff[l] &&
                    alloc_dst[k*IDX_W +: IDX_W] == alloc_dst[l*IDX_W +: IDX_W]) begin
                    err_hit = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wake_list  <= '1;
            busy_count <= '0;
            err        <= 1'b0;
        end else begin
            wake_list  <= nxt;
            busy_count <= busy_popcount(nxt);
            err        <= err | err_hit;
        end
    end

endmodule
